// File: rtl/i2c_sensor_target_if.sv
// I2C bus-side signals of the sensor target: open-drain SDA is modelled as a
// pull-low enable, SCL/SDA are the raw (unsynchronized) line levels.
interface i2c_sensor_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C target exposing a 16-bit config register and five read-only colour/IR
// channels through an auto-incrementing 8-bit register pointer.
module i2c_sensor_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h29,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_sensor_target_if.slave    bus,
  input  logic [15:0]           ch_clear,
  input  logic [15:0]           ch_red,
  input  logic [15:0]           ch_green,
  input  logic [15:0]           ch_blue,
  input  logic [15:0]           ch_ir,
  output logic [15:0]           cfg_reg,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  pointer, pointer_n;
  logic        byte_sel, byte_sel_n;
  logic        have_ptr, have_ptr_n;
  logic [7:0]  lsb_buf, lsb_buf_n;
  logic [15:0] snap, snap_n;
  logic [15:0] cfg_n;
  logic        sda_oe_q, sda_oe_n;
  logic        busy_q, busy_n;
  logic [15:0] reg_val;
  logic [7:0]  tx_byte;
  logic [2:0]  tx_idx;
  logic        rd_first_bit;

  // Synchronizers idle at 1 so reset release never looks like a START/STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_comb begin
    reg_val = 16'h0000;
    case (pointer)
      8'h00:   reg_val = cfg_reg;
      8'h01:   reg_val = ch_clear;
      8'h02:   reg_val = ch_red;
      8'h03:   reg_val = ch_green;
      8'h04:   reg_val = ch_blue;
      8'h05:   reg_val = ch_ir;
      default: reg_val = 16'h0000;
    endcase
  end

  // The first bit of a read byte comes from a fresh snapshot on the LSB byte
  assign tx_byte      = byte_sel ? snap[15:8] : snap[7:0];
  assign tx_idx       = 3'd7 - bit_cnt[2:0];
  assign rd_first_bit = byte_sel ? snap[15] : reg_val[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      pointer  <= 8'h00;
      byte_sel <= 1'b0;
      have_ptr <= 1'b0;
      lsb_buf  <= 8'h00;
      snap     <= 16'h0000;
      cfg_reg  <= 16'h0000;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      pointer  <= pointer_n;
      byte_sel <= byte_sel_n;
      have_ptr <= have_ptr_n;
      lsb_buf  <= lsb_buf_n;
      snap     <= snap_n;
      cfg_reg  <= cfg_n;
      sda_oe_q <= sda_oe_n;
      busy_q   <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    pointer_n  = pointer;
    byte_sel_n = byte_sel;
    have_ptr_n = have_ptr;
    lsb_buf_n  = lsb_buf;
    snap_n     = snap;
    cfg_n      = cfg_reg;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;

    case (state)
      IDLE: ;
      ADDR: begin
        if (scl_rise) begin
          shreg_n   = {shreg[6:0], sda_s};
          bit_cnt_n = bit_cnt + 4'd1;
        end else if (scl_fall && bit_cnt == 4'd8) begin
          if (shreg[7:1] == I2C_ADDR) begin
            state_n  = ADDR_ACK;
            sda_oe_n = 1'b1;
            busy_n   = 1'b1;
          end else begin
            state_n  = WAIT_STOP;
            busy_n   = 1'b0;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          bit_cnt_n = 4'd0;
          if (shreg[0]) begin
            state_n  = RD_BYTE;
            if (!byte_sel) snap_n = reg_val;
            sda_oe_n = ~rd_first_bit;
          end else begin
            state_n    = WR_BYTE;
            sda_oe_n   = 1'b0;
            have_ptr_n = 1'b0;
          end
        end
      end
      WR_BYTE: begin
        if (scl_rise) begin
          shreg_n   = {shreg[6:0], sda_s};
          bit_cnt_n = bit_cnt + 4'd1;
        end else if (scl_fall && bit_cnt == 4'd8) begin
          state_n  = WR_ACK;
          sda_oe_n = 1'b1;
          if (!have_ptr) begin
            pointer_n  = shreg;
            have_ptr_n = 1'b1;
          end else if (!byte_sel) begin
            lsb_buf_n  = shreg;
            byte_sel_n = 1'b1;
          end else begin
            if (pointer == 8'h00) cfg_n = {shreg, lsb_buf};
            pointer_n  = pointer + 8'd1;
            byte_sel_n = 1'b0;
          end
        end
      end
      WR_ACK: begin
        if (scl_fall) begin
          state_n   = WR_BYTE;
          sda_oe_n  = 1'b0;
          bit_cnt_n = 4'd0;
        end
      end
      RD_BYTE: begin
        if (scl_rise) begin
          bit_cnt_n = bit_cnt + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            state_n  = RD_ACK;
            sda_oe_n = 1'b0;
            if (byte_sel) begin
              pointer_n  = pointer + 8'd1;
              byte_sel_n = 1'b0;
            end else begin
              byte_sel_n = 1'b1;
            end
          end else begin
            sda_oe_n = ~tx_byte[tx_idx];
          end
        end
      end
      RD_ACK: begin
        sda_oe_n = 1'b0;
        if (scl_rise && sda_s) begin
          state_n = WAIT_STOP;
        end else if (scl_fall) begin
          state_n   = RD_BYTE;
          bit_cnt_n = 4'd0;
          if (!byte_sel) snap_n = reg_val;
          sda_oe_n  = ~rd_first_bit;
        end
      end
      WAIT_STOP: sda_oe_n = 1'b0;
      default:   state_n  = IDLE;
    endcase

    // Bus conditions override whatever the byte machinery decided
    if (start_det) begin
      state_n    = ADDR;
      bit_cnt_n  = 4'd0;
      sda_oe_n   = 1'b0;
      byte_sel_n = 1'b0;
    end else if (stop_det) begin
      state_n    = IDLE;
      bit_cnt_n  = 4'd0;
      sda_oe_n   = 1'b0;
      byte_sel_n = 1'b0;
      busy_n     = 1'b0;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bit-banged I2C controller driving i2c_sensor_target, checked against a
// register-map model of the sensor.
module tb_i2c_sensor_target;
  localparam int Q = 6;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  logic [15:0] ch_clear, ch_red, ch_green, ch_blue, ch_ir;
  logic [15:0] cfg_reg;
  logic busy;

  int errors = 0;
  int checks = 0;
  int oe_seen = 0;
  logic mon_en = 1'b0;

  logic [15:0] m_cfg;
  logic [7:0]  m_ptr;

  always #5 clk = ~clk;

  i2c_sensor_target_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_sensor_target #(.I2C_ADDR(7'h29), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ch_clear (ch_clear),
    .ch_red   (ch_red),
    .ch_green (ch_green),
    .ch_blue  (ch_blue),
    .ch_ir    (ch_ir),
    .cfg_reg  (cfg_reg),
    .busy     (busy)
  );

  always @(posedge clk) if (mon_en && bus.sda_oe) oe_seen++;

  function automatic logic [15:0] m_reg(input logic [7:0] p);
    case (p)
      8'h00:   return m_cfg;
      8'h01:   return ch_clear;
      8'h02:   return ch_red;
      8'h03:   return ch_green;
      8'h04:   return ch_blue;
      8'h05:   return ch_ir;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    s = bus.sda_i; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  // Pointer-set write transaction; leaves the bus mid-transfer (no STOP)
  task automatic apply_stimulus(input logic [7:0] ptr);
    logic ack;
    i2c_start();
    send_byte(8'h52, ack); check_output("wr_addr_ack", ack, 1);
    send_byte(ptr, ack);   check_output("ptr_ack", ack, 1);
    m_ptr = ptr;
  endtask

  initial begin
    logic ack, s;
    logic [7:0] d;
    logic [15:0] snapv, wv;
    logic [7:0] ptr;
    int npairs, nread;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    ch_clear = 16'h1111; ch_red = 16'h2222; ch_green = 16'h3333;
    ch_blue = 16'h4444; ch_ir = 16'h5555;
    m_cfg = 16'h0000; m_ptr = 8'h00;
    repeat (4) @(negedge clk);
    check_output("rst_sda_oe", bus.sda_oe, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_cfg", cfg_reg, 16'h0000);
    rst = 1'b0;
    wait_q();

    // cfg write, LSB then MSB
    apply_stimulus(8'h00);
    check_output("busy_in_write", busy, 1);
    send_byte(8'h35, ack); check_output("cfg_lsb_ack", ack, 1);
    check_output("cfg_after_lsb", cfg_reg, m_cfg);
    send_byte(8'h12, ack); check_output("cfg_msb_ack", ack, 1);
    m_cfg = 16'h1235; m_ptr = m_ptr + 8'd1;
    check_output("cfg_after_msb", cfg_reg, m_cfg);
    i2c_stop();
    check_output("busy_after_stop", busy, 0);

    // pointer write, repeated START, read red
    ch_red = 16'hBEEF;
    apply_stimulus(8'h02);
    i2c_start();
    send_byte(8'h53, ack); check_output("rd_addr_ack", ack, 1);
    recv_byte(1'b0, d); check_output("red_lsb", d, 8'hEF);
    recv_byte(1'b1, d); check_output("red_msb", d, 8'hBE);
    wait_q();
    check_output("nack_release", bus.sda_oe, 0);
    i2c_stop();
    check_output("busy_after_read", busy, 0);

    // read across into unmapped space
    ch_ir = 16'($urandom);
    apply_stimulus(8'h05);
    i2c_start();
    send_byte(8'h53, ack); check_output("rd_addr_ack", ack, 1);
    recv_byte(1'b0, d); check_output("ir_lsb", d, ch_ir[7:0]);
    recv_byte(1'b0, d); check_output("ir_msb", d, ch_ir[15:8]);
    recv_byte(1'b0, d); check_output("unmapped_lsb", d, 8'h00);
    recv_byte(1'b1, d); check_output("unmapped_msb", d, 8'h00);
    i2c_stop();

    // foreign address must be ignored entirely
    oe_seen = 0; mon_en = 1'b1;
    i2c_start();
    send_byte(8'h60, ack); check_output("foreign_noack", ack, 0);
    check_output("foreign_busy", busy, 0);
    send_byte(8'h00, ack); check_output("foreign_data_noack", ack, 0);
    send_byte(8'h77, ack);
    send_byte(8'h66, ack);
    i2c_stop();
    mon_en = 1'b0;
    check_output("foreign_sda_oe", oe_seen, 0);
    check_output("foreign_cfg", cfg_reg, m_cfg);

    // MSB comes from the snapshot taken at the LSB
    ch_green = 16'hA1B2;
    apply_stimulus(8'h03);
    i2c_start();
    send_byte(8'h53, ack);
    recv_byte(1'b0, d); check_output("green_lsb", d, 8'hB2);
    ch_green = 16'hC3D4;
    recv_byte(1'b1, d); check_output("green_msb_snapshot", d, 8'hA1);
    i2c_stop();

    // STOP mid-byte, lone LSB discarded
    apply_stimulus(8'h00);
    send_byte(8'hEE, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    i2c_stop();
    check_output("partial_cfg", cfg_reg, m_cfg);
    check_output("partial_busy", busy, 0);
    check_output("partial_sda_oe", bus.sda_oe, 0);

    // reset during the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(d[0] ^ d[0] ^ ((8'h52 >> i) & 1), s);
    sda_m = 1'b1; wait_q();
    check_output("ack_driving", bus.sda_oe, 1);
    @(negedge clk); rst = 1'b1; #1;
    check_output("rst_async_release", bus.sda_oe, 0);
    check_output("rst_busy_mid", busy, 0);
    check_output("rst_cfg_mid", cfg_reg, 16'h0000);
    m_cfg = 16'h0000; m_ptr = 8'h00;
    @(negedge clk); rst = 1'b0;
    scl_m = 1'b1; wait_q(); scl_m = 1'b0; wait_q();
    check_output("post_rst_idle", bus.sda_oe, 0);
    i2c_stop();
    apply_stimulus(8'h00);
    send_byte(8'h9A, ack); check_output("post_rst_lsb_ack", ack, 1);
    send_byte(8'h78, ack); check_output("post_rst_msb_ack", ack, 1);
    i2c_stop();
    m_cfg = 16'h789A; m_ptr = 8'h01;
    check_output("post_rst_cfg", cfg_reg, m_cfg);

    // randomized write/read transactions against the register-map model
    for (int it = 0; it < 12; it++) begin
      ch_clear = 16'($urandom); ch_red = 16'($urandom); ch_green = 16'($urandom);
      ch_blue  = 16'($urandom); ch_ir  = 16'($urandom);
      ptr = ($urandom_range(0, 7) == 7) ? 8'hFF : 8'($urandom_range(0, 6));
      npairs = $urandom_range(0, 2);
      nread  = $urandom_range(1, 2);
      apply_stimulus(ptr);
      for (int p = 0; p < npairs; p++) begin
        wv = 16'($urandom);
        send_byte(wv[7:0], ack);  check_output("rnd_wr_lsb_ack", ack, 1);
        send_byte(wv[15:8], ack); check_output("rnd_wr_msb_ack", ack, 1);
        if (m_ptr == 8'h00) m_cfg = wv;
        m_ptr = m_ptr + 8'd1;
      end
      i2c_start();
      send_byte(8'h53, ack); check_output("rnd_rd_addr_ack", ack, 1);
      for (int r = 0; r < nread; r++) begin
        snapv = m_reg(m_ptr);
        recv_byte(1'b0, d); check_output("rnd_rd_lsb", d, snapv[7:0]);
        recv_byte(r == nread - 1, d); check_output("rnd_rd_msb", d, snapv[15:8]);
        m_ptr = m_ptr + 8'd1;
      end
      i2c_stop();
      check_output("rnd_cfg", cfg_reg, m_cfg);
      check_output("rnd_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
